// File: rtl/lab1_imul_var_pkg.sv
// lab1_imul_var_pkg: state encoding and shared helpers for the
// variable-latency iterative multiplier (lab1_imul_int_mul_var).
// The request/response structs depend on NBITS and are therefore
// declared inside the top module, which owns that parameter.
package lab1_imul_var_pkg;

   // Default operand width used by the multiplier blocks.
   localparam int NBITS_DEFAULT = 32;

   // Control FSM encoding (plain constants so legacy code can compare raw values).
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;   // waiting for a request
   localparam state_t CALC = 2'd1;   // shift-add iterations in progress
   localparam state_t DONE = 2'd2;   // product valid, waiting for the sink

   // Iteration counter width: must hold NBITS itself, the value the
   // counter reaches after the last iteration, so it never wraps.
   function automatic int cnt_width(input int nbits);
      return $clog2(nbits + 1);
   endfunction

endpackage

// File: rtl/lab1_imul_var_dpath.sv
// lab1_imul_var_dpath: datapath of the iterative shift-add multiplier.
// Holds the magnitude operands, the running product, the sign of the
// result and the iteration counter. The control FSM in the top drives
// load_en (capture a new request) and calc_en (one shift-add step).
module lab1_imul_var_dpath
   import lab1_imul_var_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT
)(
   input  logic               clk,
   input  logic               reset,        // asynchronous, active-low
   input  logic               load_en,
   input  logic               calc_en,
   input  logic               req_signed,
   input  logic [NBITS-1:0]   req_a,
   input  logic [NBITS-1:0]   req_b,
   output logic               b_is_zero,
   output logic               cnt_last,
   output logic [2*NBITS-1:0] result
);

   localparam int CW = cnt_width(NBITS);

   logic [2*NBITS-1:0] a_reg;
   logic [2*NBITS-1:0] prod_reg;
   logic [NBITS-1:0]   b_reg;
   logic [CW-1:0]      cnt_reg;
   logic               neg_reg;

   logic               a_neg_in;
   logic               b_neg_in;
   logic [NBITS-1:0]   a_abs;
   logic [NBITS-1:0]   b_abs;
   logic [2*NBITS-1:0] addend;
   logic [2*NBITS-1:0] prod_sum;

   // Magnitudes are kept unsigned, so -2^(NBITS-1) maps to 2^(NBITS-1) exactly.
   assign a_neg_in = req_signed & req_a[NBITS-1];
   assign b_neg_in = req_signed & req_b[NBITS-1];
   assign a_abs    = a_neg_in ? -req_a : req_a;
   assign b_abs    = b_neg_in ? -req_b : req_b;

   // Add the shifted multiplicand only when the current multiplier bit is set.
   // The sum is 2*NBITS wide; the product of two NBITS magnitudes cannot overflow it.
   assign addend   = b_reg[0] ? a_reg : '0;
   assign prod_sum = prod_reg + addend;

   // Operand capture on accept, one shift-add step per enabled CALC cycle.
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create ordering races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         prod_reg <= '0;
         cnt_reg  <= '0;
         neg_reg  <= 1'b0;
      end else if (load_en) begin
         a_reg    <= {{NBITS{1'b0}}, a_abs};
         b_reg    <= b_abs;
         prod_reg <= '0;
         cnt_reg  <= '0;
         neg_reg  <= a_neg_in ^ b_neg_in;
      end else if (calc_en) begin
         prod_reg <= prod_sum;
         a_reg    <= a_reg << 1;
         b_reg    <= b_reg >> 1;
         cnt_reg  <= cnt_reg + CW'(1);
      end
   end

   // Status back to the FSM: remaining multiplier bits, and last iteration.
   assign b_is_zero = (b_reg == '0);
   assign cnt_last  = (cnt_reg == CW'(NBITS - 1));

   // Sign is applied combinationally to the registered magnitude product.
   assign result = neg_reg ? -prod_reg : prod_reg;

endmodule

// File: rtl/lab1_imul_int_mul_var.sv
// lab1_imul_int_mul_var: variable-latency iterative shift-add multiplier.
// Produces the full 2*NBITS-bit signed or unsigned product behind val/rdy
// request/response interfaces, one transaction in flight at a time.
// Optional build macro LAB1_IMUL_INT_MUL_VAR_EARLY_EXIT_EN: leave CALC as
// soon as the remaining multiplier bits are all zero (same results, fewer cycles).
module lab1_imul_int_mul_var
   import lab1_imul_var_pkg::*;
#(
   parameter int NBITS = 32
)(
   input  logic             clk,
   input  logic             reset,       // asynchronous, active-low
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [NBITS-1:0] req_a,
   input  logic [NBITS-1:0] req_b,
   input  logic             req_signed,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [NBITS-1:0] resp_lo,
   output logic [NBITS-1:0] resp_hi
);

   // Request and response bundles, sized by this instance's NBITS.
   typedef struct packed {
      logic             is_signed;
      logic [NBITS-1:0] a;
      logic [NBITS-1:0] b;
   } req_t;

   typedef struct packed {
      logic [NBITS-1:0] hi;
      logic [NBITS-1:0] lo;
   } resp_t;

   req_t   req;
   resp_t  resp;

   state_t state_reg;
   state_t state_next;

   logic   load_en;
   logic   calc_en;
   logic   b_is_zero;
   logic   cnt_last;
   logic   req_go;
   logic   resp_go;

   assign req = '{is_signed: req_signed, a: req_a, b: req_b};

   // Handshakes. req_rdy is also forced low while reset is held.
   assign req_rdy  = (state_reg == IDLE) && reset;
   assign resp_val = (state_reg == DONE);
   assign req_go   = req_val && req_rdy;
   assign resp_go  = resp_val && resp_rdy;

   assign load_en  = req_go;

`ifdef LAB1_IMUL_INT_MUL_VAR_EARLY_EXIT_EN
   // With early exit, a CALC cycle that finds no multiplier bits left does no update.
   assign calc_en  = (state_reg == CALC) && !b_is_zero;
`else
   logic unused_b_is_zero;
   assign unused_b_is_zero = b_is_zero;
   assign calc_en  = (state_reg == CALC);
`endif

   // State register for the IDLE/CALC/DONE controller.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic.
   // NOTE: state_next is given a default before the case so every path
   // assigns it; a missing assignment would infer a latch.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (req_go) state_next = CALC;
         CALC: begin
`ifdef LAB1_IMUL_INT_MUL_VAR_EARLY_EXIT_EN
            if (b_is_zero || cnt_last) state_next = DONE;
`else
            if (cnt_last) state_next = DONE;
`endif
         end
         DONE: if (resp_go) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   lab1_imul_var_dpath #(
      .NBITS (NBITS)
   ) dpath (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en),
      .calc_en    (calc_en),
      .req_signed (req.is_signed),
      .req_a      (req.a),
      .req_b      (req.b),
      .b_is_zero  (b_is_zero),
      .cnt_last   (cnt_last),
      .result     (resp)
   );

   assign resp_lo = resp.lo;
   assign resp_hi = resp.hi;

endmodule

// File: tb/tb_lab1_imul_int_mul_var.sv
// tb_lab1_imul_int_mul_var: directed self-checking bench for the
// variable-latency multiplier. A 32-bit instance carries most of the
// sequence; an 8-bit instance covers the small-width corner case.
// Expected products are queued when a request is accepted and popped
// when the response appears.
module tb_lab1_imul_int_mul_var;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;

   logic          req_val = 1'b0;
   logic          req_rdy;
   logic [N-1:0]  req_a = '0;
   logic [N-1:0]  req_b = '0;
   logic          req_signed = 1'b0;
   logic          resp_val;
   logic          resp_rdy = 1'b1;
   logic [N-1:0]  resp_lo;
   logic [N-1:0]  resp_hi;

   logic          r8_req_val = 1'b0;
   logic          r8_req_rdy;
   logic [7:0]    r8_req_a = '0;
   logic [7:0]    r8_req_b = '0;
   logic          r8_req_signed = 1'b0;
   logic          r8_resp_val;
   logic          r8_resp_rdy = 1'b1;
   logic [7:0]    r8_resp_lo;
   logic [7:0]    r8_resp_hi;

   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            accept_cyc = 0;
   logic [63:0]   sb[$];

   lab1_imul_int_mul_var #(.NBITS(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_val    (req_val),
      .req_rdy    (req_rdy),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .resp_val   (resp_val),
      .resp_rdy   (resp_rdy),
      .resp_lo    (resp_lo),
      .resp_hi    (resp_hi)
   );

   lab1_imul_int_mul_var #(.NBITS(8)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .req_val    (r8_req_val),
      .req_rdy    (r8_req_rdy),
      .req_a      (r8_req_a),
      .req_b      (r8_req_b),
      .req_signed (r8_req_signed),
      .resp_val   (r8_resp_val),
      .resp_rdy   (r8_resp_rdy),
      .resp_lo    (r8_resp_lo),
      .resp_hi    (r8_resp_hi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Reference product: sign- or zero-extend to 64 bits and multiply.
   function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic [63:0] xa;
      logic [63:0] xb;
      xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      return xa * xb;
   endfunction

   // Cycles from the accept edge (counted as 1) until resp_val is seen.
   function automatic int exp_lat(input logic [63:0] b, input logic sgn, input int nbits);
`ifdef LAB1_IMUL_INT_MUL_VAR_EARLY_EXIT_EN
      logic [63:0] mask;
      logic [63:0] mag;
      int          k;
      int          calc;
      mask = (64'd1 << nbits) - 64'd1;
      mag  = (sgn && b[nbits-1]) ? ((~b + 64'd1) & mask) : (b & mask);
      k = -1;
      for (int i = 0; i < nbits; i++) if (mag[i]) k = i;
      if (k < 0) return 2;
      calc = (k + 2 < nbits) ? k + 2 : nbits;
      return calc + 1;
`else
      logic unused_args;
      unused_args = ^{b, sgn};
      return nbits + 1;
`endif
   endfunction

   // Offer a request and wait (bounded) for it to be accepted.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic [63:0] exp);
      int guard;
      guard = 0;
      req_val = 1'b1; req_a = a; req_b = b; req_signed = sgn;
      while (!req_rdy && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      check("req_rdy_wait", 64'(req_rdy), 64'd1);
      sb.push_back(exp);
      @(posedge clk); #1;
      accept_cyc = cyc;
      req_val = 1'b0;
   endtask

   // Wait (bounded) for the response, compare it, then complete the
   // handshake if the sink is ready.
   task automatic recv(input int lat);
      int          guard;
      logic [63:0] e;
      guard = 0;
      e = '0;
      while (!resp_val && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      check("resp_val_wait", 64'(resp_val), 64'd1);
      check("latency", 64'(cyc - accept_cyc + 1), 64'(lat));
      check("sb_depth", 64'(sb.size()), 64'd1);
      if (sb.size() != 0) e = sb.pop_front();
      check("product", {resp_hi, resp_lo}, e);
      if (resp_rdy) begin
         @(posedge clk); #1;
         check("idle_after_ack", 64'({req_rdy, resp_val}), 64'b10);
      end
   endtask

   // One complete transaction on the 8-bit instance.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn, input logic [15:0] exp);
      int guard;
      int t0;
      guard = 0;
      r8_req_val = 1'b1; r8_req_a = a; r8_req_b = b; r8_req_signed = sgn;
      check("r8_req_rdy", 64'(r8_req_rdy), 64'd1);
      @(posedge clk); #1;
      t0 = cyc;
      r8_req_val = 1'b0;
      while (!r8_resp_val && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      check("r8_resp_val", 64'(r8_resp_val), 64'd1);
      check("r8_latency", 64'(cyc - t0 + 1), 64'(exp_lat({56'b0, b}, sgn, 8)));
      check("r8_product", 64'({r8_resp_hi, r8_resp_lo}), 64'(exp));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;

      // Reset state
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_rdy", 64'(req_rdy), 64'd0);
      check("rst_resp_val", 64'(resp_val), 64'd0);
      check("rst_product", {resp_hi, resp_lo}, 64'd0);
      check("rst_r8_req_rdy", 64'(r8_req_rdy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_req_rdy", 64'({req_rdy, resp_val}), 64'b10);

      // Basic products, signed and unsigned
      send(32'd3, 32'd4, 1'b0, 64'h0000_0000_0000_000C);
      recv(exp_lat(64'd4, 1'b0, N));
      send(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
      recv(exp_lat(64'd5, 1'b1, N));
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
      recv(exp_lat(64'h0000_0000_FFFF_FFFF, 1'b1, N));

      // Width extremes and most-negative operand
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      recv(exp_lat(64'h0000_0000_FFFF_FFFF, 1'b0, N));
      send(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      recv(exp_lat(64'h0000_0000_8000_0000, 1'b1, N));
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
      recv(exp_lat(64'h0000_0000_FFFF_FFFF, 1'b1, N));

      // Latency corners: b = 0, b = 1, |b| = 1 from a signed -1
      send(32'h1234_5678, 32'd0, 1'b0, 64'd0);
      recv(exp_lat(64'd0, 1'b0, N));
      send(32'h1234_5678, 32'd1, 1'b0, 64'h0000_0000_1234_5678);
      recv(exp_lat(64'd1, 1'b0, N));
      send(32'd5, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
      recv(exp_lat(64'h0000_0000_FFFF_FFFF, 1'b1, N));

      // Random operands of varied multiplier length
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         rs = 1'($urandom_range(0, 1));
         send(ra, rb, rs, model32(ra, rb, rs));
         recv(exp_lat({32'b0, rb}, rs, N));
      end

      // Backpressure: result must hold and no new request may be taken
      resp_rdy = 1'b0;
      send(32'd1000, 32'd77, 1'b0, 64'd77000);
      recv(exp_lat(64'd77, 1'b0, N));
      req_val = 1'b1; req_a = 32'd9; req_b = 32'd11; req_signed = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_resp_val", 64'(resp_val), 64'd1);
         check("bp_req_rdy", 64'(req_rdy), 64'd0);
         check("bp_product", {resp_hi, resp_lo}, 64'd77000);
      end
      resp_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_release", 64'({req_rdy, resp_val}), 64'b10);
      // req_val is still high, so this is accepted on the very next edge
      send(32'd9, 32'd11, 1'b0, 64'd99);
      check("bp_same_cycle_accept", 64'(cyc - accept_cyc), 64'd0);
      recv(exp_lat(64'd11, 1'b0, N));

      // Reset in the middle of CALC discards the in-flight product
      send(32'h0001_2345, 32'h0000_FFFF, 1'b0, model32(32'h0001_2345, 32'h0000_FFFF, 1'b0));
      repeat (5) @(posedge clk);
      #1;
      check("mid_calc_busy", 64'({req_rdy, resp_val}), 64'b00);
      reset = 1'b0;
      #1;
      check("mid_rst_req_rdy", 64'(req_rdy), 64'd0);
      check("mid_rst_resp_val", 64'(resp_val), 64'd0);
      check("mid_rst_product", {resp_hi, resp_lo}, 64'd0);
      sb.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("post_rst_idle", 64'({req_rdy, resp_val}), 64'b10);
      end
      send(32'd7, 32'd6, 1'b0, 64'd42);
      recv(exp_lat(64'd6, 1'b0, N));

      // Narrow instance
      run8(8'h80, 8'h80, 1'b1, 16'h4000);
      run8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
      run8(8'h80, 8'h7F, 1'b1, 16'hC080);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
